// File: rtl/detector_jogada_if.sv
// Bus between the game controller and the move detector: control inputs,
// raw buttons and the accepted-move outputs.
interface detector_jogada_if;
   logic       zera;
   logic       habilita;
   logic [8:0] botoes;
   logic       tem_jogada;
   logic [3:0] jogada;
   logic [2:0] db_estado;

   modport master (
      output zera,
      output habilita,
      output botoes,
      input  tem_jogada,
      input  jogada,
      input  db_estado
   );

   modport slave (
      input  zera,
      input  habilita,
      input  botoes,
      output tem_jogada,
      output jogada,
      output db_estado
   );
endinterface

// File: rtl/detector_jogada.sv
// Move detector: synchronizes and debounces the nine cell buttons, rejects
// multi-button presses and emits a one-cycle pulse with the accepted index.
module detector_jogada #(
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int W_CNT           = 16
) (
   input logic               clock,
   input logic               reset,
   detector_jogada_if.slave  bus
);

   typedef enum logic [2:0] {
      OCIOSO        = 3'd0,
      FILTRA        = 3'd1,
      EMITE         = 3'd2,
      ESPERA_SOLTAR = 3'd3
   } estado_t;

   localparam logic [W_CNT-1:0] CNT_MAX  = W_CNT'(DEBOUNCE_CICLOS - 1);
   localparam logic [W_CNT-1:0] CNT_ZERO = {W_CNT{1'b0}};
   localparam logic [W_CNT-1:0] CNT_ONE  = {{(W_CNT-1){1'b0}}, 1'b1};

   // True when exactly one button is pressed.
   function automatic logic is_one_hot(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

   // Index of the pressed button; only meaningful for a one-hot vector.
   function automatic logic [3:0] encode(input logic [8:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (v[i]) begin
            idx = 4'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   estado_t          state_q, state_d;
   logic [W_CNT-1:0] cnt_q, cnt_d, cnt_inc_s;
   logic [8:0]       sync1_q, bsync_q;
   logic [8:0]       cand_q, cand_d;
   logic [3:0]       idx_q, idx_d;
   logic [3:0]       jogada_q, jogada_d;
   logic             tem_jogada_q;

   assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

   // Two-flop synchronizer for the raw asynchronous buttons.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 9'd0;
         bsync_q <= 9'd0;
      end else if (bus.zera) begin
         sync1_q <= 9'd0;
         bsync_q <= 9'd0;
      end else begin
         sync1_q <= bus.botoes;
         bsync_q <= sync1_q;
      end
   end

   // FSM state, debounce counter, candidate and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= OCIOSO;
         cnt_q        <= CNT_ZERO;
         cand_q       <= 9'd0;
         idx_q        <= 4'd0;
         jogada_q     <= 4'd0;
         tem_jogada_q <= 1'b0;
      end else if (bus.zera) begin
         state_q      <= OCIOSO;
         cnt_q        <= CNT_ZERO;
         cand_q       <= 9'd0;
         idx_q        <= 4'd0;
         jogada_q     <= 4'd0;
         tem_jogada_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cand_q       <= cand_d;
         idx_q        <= idx_d;
         jogada_q     <= jogada_d;
         tem_jogada_q <= (state_d == EMITE);
      end
   end

   // Next-state logic; the counter is cleared on every state change.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cand_d   = cand_q;
      idx_d    = idx_q;
      jogada_d = jogada_q;
      case (state_q)
         OCIOSO: begin
            cnt_d = CNT_ZERO;
            if (bus.habilita && is_one_hot(bsync_q)) begin
               cand_d  = bsync_q;
               idx_d   = encode(bsync_q);
               state_d = FILTRA;
            end else if (bus.habilita && (bsync_q != 9'd0)) begin
               state_d = ESPERA_SOLTAR;
            end else begin
               state_d = OCIOSO;
            end
         end
         FILTRA: begin
            if ((bsync_q != cand_q) || !bus.habilita) begin
               state_d = OCIOSO;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_MAX) begin
               state_d  = EMITE;
               cnt_d    = CNT_ZERO;
               jogada_d = idx_q;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         EMITE: begin
            state_d = ESPERA_SOLTAR;
            cnt_d   = CNT_ZERO;
         end
         ESPERA_SOLTAR: begin
            if (bsync_q != 9'd0) begin
               cnt_d = CNT_ZERO;
            end else if (cnt_q == CNT_MAX) begin
               state_d = OCIOSO;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         default: begin
            state_d = OCIOSO;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   assign bus.tem_jogada = tem_jogada_q;
   assign bus.jogada     = jogada_q;
   assign bus.db_estado  = state_q;

endmodule
